// File: rtl/compare_result_tracker.sv
// compare_result_tracker
// Consumes greater/less/equal flags from a 4-bit magnitude comparator.
// Keeps saturating per-class event counters. Tracks runs of equal results
// and declares lock after RUN_LEN consecutive legal equal samples. Raises a
// sticky error when a valid sample is not one-hot.
// All outputs are registered and reflect a sample one clock edge later.

module compare_result_tracker #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             greater_than,
  input  logic             less_than,
  input  logic             equal,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic             lock,
  output logic             lock_lost,
  output logic             err_flag
);

  // Wide enough to hold the value RUN_LEN itself.
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  // A comparator sample is meaningful only with exactly one flag set.
  function automatic logic is_one_hot(input logic g, input logic l, input logic e);
    return ({g, l, e} == 3'b100) || ({g, l, e} == 3'b010) || ({g, l, e} == 3'b001);
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [RUN_W-1:0]   run_r;
  logic [RUN_W-1:0]   run_next_s;
  logic [CNT_W-1:0]   gt_cnt_r;
  logic [CNT_W-1:0]   lt_cnt_r;
  logic [CNT_W-1:0]   eq_cnt_r;
  logic [CNT_W-1:0]   gt_cnt_next_s;
  logic [CNT_W-1:0]   lt_cnt_next_s;
  logic [CNT_W-1:0]   eq_cnt_next_s;
  logic               err_r;
  logic               err_next_s;
  logic               lock_r;
  logic               lock_lost_r;
  logic               lock_lost_next_s;
  logic               one_hot_s;

  assign one_hot_s = is_one_hot(greater_than, less_than, equal);

  // Next-state, run tracking, counter and error update for the current sample.
  always_comb begin
    state_next_s     = state_r;
    run_next_s       = run_r;
    gt_cnt_next_s    = gt_cnt_r;
    lt_cnt_next_s    = lt_cnt_r;
    eq_cnt_next_s    = eq_cnt_r;
    err_next_s       = err_r;
    lock_lost_next_s = 1'b0;

    if (clear) begin
      // Clear wins over a coincident sample; that sample is discarded.
      state_next_s  = ST_SEARCH;
      run_next_s    = {RUN_W{1'b0}};
      gt_cnt_next_s = {CNT_W{1'b0}};
      lt_cnt_next_s = {CNT_W{1'b0}};
      eq_cnt_next_s = {CNT_W{1'b0}};
      err_next_s    = 1'b0;
    end else if (!in_valid) begin
      // Idle cycle: everything holds.
      state_next_s = state_r;
    end else if (!one_hot_s) begin
      // Illegal flag combination: remember it, leave counters and FSM alone.
      err_next_s = 1'b1;
    end else begin
      if (greater_than) begin
        gt_cnt_next_s = sat_inc(gt_cnt_r);
      end else if (less_than) begin
        lt_cnt_next_s = sat_inc(lt_cnt_r);
      end else begin
        eq_cnt_next_s = sat_inc(eq_cnt_r);
      end

      case (state_r)
        ST_SEARCH: begin
          if (equal) begin
            run_next_s = RUN_W'(1);
            if (RUN_LEN == 1) begin
              state_next_s = ST_LOCKED;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            run_next_s   = {RUN_W{1'b0}};
            state_next_s = ST_SEARCH;
          end
        end
        ST_RUN: begin
          if (equal) begin
            run_next_s = run_r + RUN_W'(1);
            if ((run_r + RUN_W'(1)) == RUN_W'(RUN_LEN)) begin
              state_next_s = ST_LOCKED;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            run_next_s   = {RUN_W{1'b0}};
            state_next_s = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (equal) begin
            state_next_s = ST_LOCKED;
          end else begin
            run_next_s       = {RUN_W{1'b0}};
            state_next_s     = ST_SEARCH;
            lock_lost_next_s = 1'b1;
          end
        end
        default: begin
          run_next_s   = {RUN_W{1'b0}};
          state_next_s = ST_SEARCH;
        end
      endcase
    end
  end

  // State, run, counter and flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_SEARCH;
      run_r       <= {RUN_W{1'b0}};
      gt_cnt_r    <= {CNT_W{1'b0}};
      lt_cnt_r    <= {CNT_W{1'b0}};
      eq_cnt_r    <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
      lock_r      <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      run_r       <= run_next_s;
      gt_cnt_r    <= gt_cnt_next_s;
      lt_cnt_r    <= lt_cnt_next_s;
      eq_cnt_r    <= eq_cnt_next_s;
      err_r       <= err_next_s;
      lock_r      <= (state_next_s == ST_LOCKED);
      lock_lost_r <= lock_lost_next_s;
    end
  end

  assign gt_count  = gt_cnt_r;
  assign lt_count  = lt_cnt_r;
  assign eq_count  = eq_cnt_r;
  assign lock      = lock_r;
  assign lock_lost = lock_lost_r;
  assign err_flag  = err_r;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Self-checking bench for compare_result_tracker.
// Reference model tracks counts as integers and the equal streak length;
// lock is simply "streak >= RUN_LEN".

module tb_compare_result_tracker;

  localparam int CNT_W   = 4;
  localparam int RUN_LEN = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             greater_than;
  logic             less_than;
  logic             equal;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] eq_count;
  logic             lock;
  logic             lock_lost;
  logic             err_flag;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_gt, m_lt, m_eq, m_streak;
  bit m_locked, m_lost, m_err;

  compare_result_tracker #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .greater_than(greater_than), .less_than(less_than), .equal(equal),
    .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count),
    .lock(lock), .lock_lost(lock_lost), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gt_count"},  32'(gt_count),  32'(m_gt));
    check({tag, ".lt_count"},  32'(lt_count),  32'(m_lt));
    check({tag, ".eq_count"},  32'(eq_count),  32'(m_eq));
    check({tag, ".lock"},      32'(lock),      32'(m_locked));
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
    check({tag, ".err_flag"},  32'(err_flag),  32'(m_err));
  endtask

  task automatic model_reset();
    m_gt = 0; m_lt = 0; m_eq = 0; m_streak = 0;
    m_locked = 1'b0; m_lost = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_update(input bit v, input bit g, input bit l, input bit e, input bit c);
    m_lost = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if ((int'(g) + int'(l) + int'(e)) != 1) begin
        m_err = 1'b1;
      end else if (e) begin
        if (m_eq < CMAX) m_eq++;
        if (m_streak < RUN_LEN) m_streak++;
        m_locked = (m_streak >= RUN_LEN);
      end else begin
        if (g && m_gt < CMAX) m_gt++;
        if (l && m_lt < CMAX) m_lt++;
        m_lost   = m_locked;
        m_locked = 1'b0;
        m_streak = 0;
      end
    end
  endtask

  task automatic step(input string tag, input bit v, input bit g, input bit l, input bit e,
                      input bit c);
    @(negedge clk);
    in_valid = v; greater_than = g; less_than = l; equal = e; clear = c;
    @(posedge clk);
    #1;
    model_update(v, g, l, e, c);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    greater_than = 1'b0; less_than = 1'b0; equal = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: 3 gt, 2 lt
    repeat (3) step("s1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step("s1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s1_gt_const", 32'(gt_count), 32'd3);
    check("s1_lt_const", 32'(lt_count), 32'd2);
    check("s1_lock_const", 32'(lock), 32'd0);

    // 2: lock after 4 equal, lose it on lt
    repeat (3) step("s2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s2_nolock3", 32'(lock), 32'd0);
    step("s2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s2_lock4", 32'(lock), 32'd1);
    step("s2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s2_lost", 32'(lock_lost), 32'd1);
    check("s2_unlock", 32'(lock), 32'd0);
    idle("s2");
    check("s2_lost_pulse", 32'(lock_lost), 32'd0);

    // 3: broken run never locks
    step("s3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step("s3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("s3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step("s3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s3_eq_const", 32'(eq_count), 32'd6);
    check("s3_gt_const", 32'(gt_count), 32'd1);
    check("s3_lock_const", 32'(lock), 32'd0);

    // 4: idle gaps do not break the run
    step("s4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("s4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("s4"); idle("s4");
    step("s4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("s4");
    repeat (2) step("s4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4_lock_const", 32'(lock), 32'd1);

    // 5: illegal samples set sticky error; lock holds
    step("s5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("s5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("s5");
    check("s5_err_const", 32'(err_flag), 32'd1);
    check("s5_lock_hold", 32'(lock), 32'd1);
    step("s5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s5_err_clr", 32'(err_flag), 32'd0);

    // 6: saturation, async reset mid-lock, clear vs coincident eq
    repeat (20) step("s6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s6_sat_const", 32'(gt_count), 32'd15);
    repeat (RUN_LEN) step("s6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s6_locked", 32'(lock), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("s6_async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step("s6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("s6_clr_eq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("s6_clr_eq_const", 32'(eq_count), 32'd0);

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      bit v, g, l, e, c;
      sel = int'($urandom_range(0, 99));
      c = (sel < 2);
      v = (sel >= 10);
      g = 1'b0; l = 1'b0; e = 1'b0;
      if (sel < 10) begin
        {g, l, e} = 3'($urandom);
      end else if (sel < 14) begin
        {g, l, e} = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      end else if (sel < 60) begin
        e = 1'b1;
      end else if (sel < 80) begin
        g = 1'b1;
      end else begin
        l = 1'b1;
      end
      step("rand", v, g, l, e, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
